// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - receiver FSM states, oversampling constants and baud divider helper (UART_PARITY_EN adds the PARITY state)
package uart_receiver_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_IDX = 7;

  typedef enum logic [2:0] {
    UART_RX_IDLE   = 3'd0,
    UART_RX_START  = 3'd1,
    UART_RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    UART_RX_PARITY = 3'd3,
`endif
    UART_RX_STOP   = 3'd4,
    UART_RX_BREAK  = 3'd5
  } uart_rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_mhz, input int baud);
    longint num;
    longint den;
    num = longint'(clk_mhz) * 64'sd1000000;
    den = longint'(baud) * longint'(OVERSAMPLE);
    return int'((num + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous byte FIFO with first-word-fall-through read port and occupancy count
module uart_rx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    din,
  input  logic          rd_en,
  output logic [7:0]    dout,
  output logic          valid,
  output logic [AW:0]   count,
  output logic          full
);

  localparam int DEPTH = 2 ** AW;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra bit so full and empty differ; count is their difference.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW + 1)'(DEPTH));
  assign valid = (count != '0);

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands when a pop frees a slot.
  assign do_pop  = rd_en && valid;
  assign do_push = wr_en && (!full || do_pop);

  // Head byte is shown without a read request; 0 when nothing is held.
  assign dout = valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage write; contents need no reset since valid gates dout.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampled UART receiver with FWFT byte FIFO and sticky errors; UART_PARITY_EN enables even parity
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLK_FREQ  = 50,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_AW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  input  logic               rd_en,
  input  logic               clr,
  output logic [7:0]         dout,
  output logic               valid,
  output logic [FIFO_AW:0]   count,
  output logic               frame_err,
  output logic               par_err,
  output logic               overflow
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  uart_rx_state_e state;
  uart_rx_state_e state_nxt;

  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       os_cnt;
  logic             sample;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             push;
  logic             frame_set;
  logic             fifo_full;
  logic             ovf_set;
`ifdef UART_PARITY_EN
  logic             bad;
  logic             par_set;
`endif

  // Two-flop synchroniser; idle-high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick   = (div_cnt == DIV_W'(DIV - 1));
  assign sample = tick && (os_cnt == 4'(SAMPLE_IDX));

  // Free-running oversample tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + DIV_W'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UART_RX_IDLE;
    else state <= state_nxt;
  end

  // Next state and per-frame outcome strobes.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_PARITY_EN
    par_set   = 1'b0;
`endif
    case (state)
      UART_RX_IDLE:  if (!rx_s) state_nxt = UART_RX_START;
      UART_RX_START: if (sample) state_nxt = rx_s ? UART_RX_IDLE : UART_RX_DATA;
      UART_RX_DATA: begin
        if (sample && bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
          state_nxt = UART_RX_PARITY;
`else
          state_nxt = UART_RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      UART_RX_PARITY: if (sample) state_nxt = UART_RX_STOP;
`endif
      UART_RX_STOP: begin
        if (sample) begin
          if (!rx_s) begin
            frame_set = 1'b1;
            state_nxt = UART_RX_BREAK;
          end
`ifdef UART_PARITY_EN
          else if (bad) begin
            par_set   = 1'b1;
            state_nxt = UART_RX_IDLE;
          end
`endif
          else begin
            push      = 1'b1;
            state_nxt = UART_RX_IDLE;
          end
        end
      end
      UART_RX_BREAK: if (rx_s) state_nxt = UART_RX_IDLE;
      default:       state_nxt = UART_RX_IDLE;
    endcase
  end

  // Bit timing, data shift (LSB first) and parity tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_PARITY_EN
      bad     <= 1'b0;
`endif
    end else begin
      if (state == UART_RX_IDLE) os_cnt <= '0;
      else if (tick) os_cnt <= os_cnt + 4'd1;
      if (state == UART_RX_START) begin
        bit_cnt <= '0;
`ifdef UART_PARITY_EN
        bad     <= 1'b0;
`endif
      end
      if (state == UART_RX_DATA && sample) begin
        shift   <= {rx_s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
`ifdef UART_PARITY_EN
      if (state == UART_RX_PARITY && sample) bad <= (^shift) ^ rx_s;
`endif
    end
  end

  assign ovf_set = push && fifo_full && !rd_en;

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (frame_set) frame_err <= 1'b1;
      else if (clr) frame_err <= 1'b0;
      if (ovf_set) overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  // Sticky parity error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else if (par_set) par_err <= 1'b1;
    else if (clr) par_err <= 1'b0;
  end
`else
  assign par_err = 1'b0;
`endif

  uart_rx_fifo #(
    .AW(FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (push),
    .din   (shift),
    .rd_en (rd_en),
    .dout  (dout),
    .valid (valid),
    .count (count),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver against a queue-based frame model
module tb_uart_receiver;

  localparam int CLK_FREQ  = 50;
  localparam int BAUD_RATE = 781250;
  localparam int FIFO_AW   = 4;
  localparam int DEPTH     = 2 ** FIFO_AW;
  localparam int DIV_REF   = (CLK_FREQ * 1000000 + BAUD_RATE * 8) / (BAUD_RATE * 16);
  localparam int BIT_CLKS  = DIV_REF * 16;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rx;
  logic             rd_en;
  logic             clr;
  logic [7:0]       dout;
  logic             valid;
  logic [FIFO_AW:0] count;
  logic             frame_err;
  logic             par_err;
  logic             overflow;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic       m_frame = 1'b0;
  logic       m_par   = 1'b0;
  logic       m_ovf   = 1'b0;

  uart_receiver #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rd_en    (rd_en),
    .clr      (clr),
    .dout     (dout),
    .valid    (valid),
    .count    (count),
    .frame_err(frame_err),
    .par_err  (par_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_dout;
    exp_dout = (q.size() != 0) ? q[0] : 8'h00;
    check({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".dout"}, 32'(dout), 32'(exp_dout));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(m_frame));
    check({tag, ".par_err"}, 32'(par_err), 32'(m_par));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] d, input logic stop_bit, input logic par_good);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_good ? ^d : ~^d);
    drive_bit(stop_bit);
  endtask

  // Frame outcome from the line rules: stop low beats parity, parity beats storage.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic par_good);
    if (!stop_bit) m_frame = 1'b1;
    else if (PAR_EN && !par_good) m_par = 1'b1;
    else if (q.size() == DEPTH) m_ovf = 1'b1;
    else q.push_back(d);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_good);
    send_raw(d, stop_bit, par_good);
    model_frame(d, stop_bit, par_good);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_frame = 1'b0;
    m_par   = 1'b0;
    m_ovf   = 1'b0;
  endtask

  initial begin
    int         lat;
    logic       hit;
    logic [7:0] b;

    rst_n = 1'b0;
    rx    = 1'b1;
    rd_en = 1'b0;
    clr   = 1'b0;
    repeat (5) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // 0xA5: head byte must appear around mid stop bit (sync + 8 oversample ticks).
    drive_bit(1'b0);
    b = 8'hA5;
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    rx = 1'b1;
    check("a5.pre_stop_valid", 32'(valid), 32'd0);
    lat = 0;
    while (!valid && lat < BIT_CLKS) begin
      @(negedge clk);
      lat++;
    end
    check("a5.latency_window", 32'((lat >= 28 && lat <= 40) ? 1 : 0), 32'd1);
    q.push_back(8'hA5);
    check_state("a5.first");
    repeat (BIT_CLKS - lat) @(negedge clk);
    pop();
    check_state("a5.popped");

    // Short low pulse must be rejected at the start-bit sample.
    rx = 1'b0;
    repeat ($urandom_range(4, 16)) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_state("glitch");

    // Random bytes, random gaps and random reads.
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b1);
      check_state($sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) pop();
      repeat ($urandom_range(0, 100)) @(negedge clk);
    end
    while (q.size() != 0) pop();
    check_state("rand.drained");

    // Low stop bit followed by a long break: exactly one frame error.
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (300) @(negedge clk);
    check_state("break.flagged");
    pulse_clr();
    repeat (400) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check_state("break.single_err");
    send_frame(8'h11, 1'b1, 1'b1);
    check_state("break.next_ok");
    pop();

    // Fill past capacity with no reads.
    for (int n = 0; n <= 16; n++) send_frame(8'(n), 1'b1, 1'b1);
    check_state("ovf.full");
    pulse_clr();
    check_state("ovf.cleared");

    // Pop in the very cycle 0x55 is pushed into the full FIFO.
    hit = 1'b0;
    fork
      send_raw(8'h55, 1'b1, 1'b1);
      begin
        for (int n = 0; n < 12 * BIT_CLKS && !hit; n++) begin
          @(negedge clk);
          if (dut.push) begin
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            hit = 1'b1;
          end
        end
      end
    join
    check("same_cycle.push_seen", 32'(hit), 32'd1);
    void'(q.pop_front());
    q.push_back(8'h55);
    check_state("same_cycle");
    for (int n = 0; n < DEPTH; n++) begin
      check($sformatf("drain%0d.dout", n), 32'(dout), 32'(q[0]));
      pop();
    end
    check_state("drain.empty");

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b0);
      check_state("par.bad");
      pulse_clr();
      send_frame(8'h07, 1'b1, 1'b1);
      check_state("par.good");
      pop();
    end

    // Reset in the middle of a frame with data and a sticky flag held.
    send_frame(8'($urandom), 1'b1, 1'b1);
    send_frame(8'h99, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_state("pre_rst");
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    rx    = 1'b1;
    q.delete();
    m_frame = 1'b0;
    m_par   = 1'b0;
    m_ovf   = 1'b0;
    repeat (3) @(negedge clk);
    check_state("rst.during");
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_state("rst.after");
    send_frame(8'h42, 1'b1, 1'b1);
    check_state("rst.next");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
